// File: rtl/command_handler.sv
// Byte-stream interpreter for the character display: printable writes, control characters,
// VT52 escapes and offset-based scrolling onto a 64x16 character buffer write port.
module command_handler (
  input  logic       pclk,
  input  logic       clr,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [9:0] buf_addr,
  output logic [7:0] buf_din,
  output logic       buf_wen,
  output logic [5:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic [3:0] first_row
);

  localparam logic [7:0] BLANK = 8'h20;

  typedef enum logic [2:0] {StIdle, StEsc, StYRow, StYCol, StClear} state_e;

  state_e     state_q, state_d;
  logic [5:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;
  logic [3:0] fr_q, fr_d;
  logic [3:0] row_arg_q, row_arg_d;
  logic [9:0] clr_idx_q, clr_idx_d;
  logic [9:0] clr_end_q, clr_end_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic       wen_q, wen_d;

  logic       accept;
  logic [7:0] arg;
  logic [3:0] arg_row;
  logic [5:0] arg_col;
  logic [3:0] cur_phys;
  logic [3:0] clr_phys;

  assign data_ready = (state_q != StClear);
  assign accept     = data_valid & data_ready;

  // ESC Y arguments are offset by 0x20; anything below the offset lands on 0
  assign arg      = (data_in < 8'h20) ? 8'h00 : data_in - 8'h20;
  assign arg_row  = (arg > 8'd15) ? 4'd15 : arg[3:0];
  assign arg_col  = (arg > 8'd63) ? 6'd63 : arg[5:0];
  assign cur_phys = cy_q + fr_q;
  assign clr_phys = clr_idx_q[9:6] + fr_q;

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    fr_d      = fr_q;
    row_arg_d = row_arg_q;
    clr_idx_d = clr_idx_q;
    clr_end_d = clr_end_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wen_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (data_in >= 8'h20 && data_in <= 8'h7E) begin
            wen_d  = 1'b1;
            addr_d = {cur_phys, cx_q};
            din_d  = data_in;
            if (cx_q != 6'd63) cx_d = cx_q + 6'd1;
          end else begin
            case (data_in)
              8'h0D: cx_d = 6'd0;
              8'h08: if (cx_q != 6'd0) cx_d = cx_q - 6'd1;
              8'h0A: begin
                if (cy_q != 4'd15) begin
                  cy_d = cy_q + 4'd1;
                end else begin
                  // Scroll: the old top row becomes logical row 15 and is blanked
                  fr_d      = fr_q + 4'd1;
                  clr_idx_d = {4'd15, 6'd0};
                  clr_end_d = {4'd15, 6'd63};
                  state_d   = StClear;
                end
              end
              8'h1B:   state_d = StEsc;
              default: ;
            endcase
          end
        end
      end

      StEsc: begin
        if (accept) begin
          state_d = StIdle;
          case (data_in)
            8'h41: if (cy_q != 4'd0) cy_d = cy_q - 4'd1;
            8'h42: if (cy_q != 4'd15) cy_d = cy_q + 4'd1;
            8'h43: if (cx_q != 6'd63) cx_d = cx_q + 6'd1;
            8'h44: if (cx_q != 6'd0) cx_d = cx_q - 6'd1;
            8'h48: begin
              cx_d = 6'd0;
              cy_d = 4'd0;
            end
            8'h4B: begin
              clr_idx_d = {cy_q, cx_q};
              clr_end_d = {cy_q, 6'd63};
              state_d   = StClear;
            end
            8'h4A: begin
              clr_idx_d = {cy_q, cx_q};
              clr_end_d = {4'd15, 6'd63};
              state_d   = StClear;
            end
            8'h59:   state_d = StYRow;
            default: ;
          endcase
        end
      end

      StYRow: begin
        if (accept) begin
          row_arg_d = arg_row;
          state_d   = StYCol;
        end
      end

      StYCol: begin
        if (accept) begin
          cx_d    = arg_col;
          cy_d    = row_arg_q;
          state_d = StIdle;
        end
      end

      StClear: begin
        wen_d  = 1'b1;
        addr_d = {clr_phys, clr_idx_q[5:0]};
        din_d  = BLANK;
        if (clr_idx_q == clr_end_q) state_d = StIdle;
        else                        clr_idx_d = clr_idx_q + 10'd1;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      cx_q      <= 6'd0;
      cy_q      <= 4'd0;
      fr_q      <= 4'd0;
      row_arg_q <= 4'd0;
      clr_idx_q <= 10'd0;
      clr_end_q <= 10'd0;
      addr_q    <= 10'd0;
      din_q     <= BLANK;
      wen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      fr_q      <= fr_d;
      row_arg_q <= row_arg_d;
      clr_idx_q <= clr_idx_d;
      clr_end_q <= clr_end_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wen_q     <= wen_d;
    end
  end

  assign buf_addr  = addr_q;
  assign buf_din   = din_q;
  assign buf_wen   = wen_q;
  assign cursor_x  = cx_q;
  assign cursor_y  = cy_q;
  assign first_row = fr_q;

endmodule

// File: doc/command_handler.md
# command_handler

Upstream stage of the character display pipeline: consumes the incoming byte stream (host/UART side) and turns it into writes to the character buffer's write port plus cursor position updates. It interprets printable characters, the basic control characters and the VT52 escape sequences. Scrolling is done by moving a top-row offset and blanking the recycled line, not by copying buffer contents. The display path reads the buffer, cursor and offset outputs unchanged.

## Interface
- `BLANK`, 8'h20: fill character for clears and scroll.
- Geometry is fixed at 64 columns × 16 rows; buffer address is 10 bits.

- `pclk` input 1: pixel clock. This block's only clock, shared with the buffer.
- `clr` input 1: reset, asynchronous, active-high.
- `data_in` input 8: incoming byte.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: byte accepted on a rising `pclk` when `data_valid & data_ready`.
- `buf_addr` output 10: buffer write address, `{phys_row[3:0], col[5:0]}`.
- `buf_din` output 8: buffer write data.
- `buf_wen` output 1: buffer write enable, one write per cycle.
- `cursor_x` output 6: cursor column, 0–63.
- `cursor_y` output 4: cursor logical row, 0–15.
- `first_row` output 4: physical buffer row shown at the top of the screen.

## Operation
- **Address mapping.** `phys_row = (logical_row + first_row) mod 16`, using 4-bit wrap.
- **States:**
  - IDLE
  - ESC: after 0x1B
  - Y_ROW, Y_COL: ESC Y arguments
  - CLEAR: multi-cycle blank-fill
- **In IDLE:**
  - **Printable character, 0x20–0x7E:**
    - Write it at the cursor.
    - If `cursor_x<63`, increment `cursor_x`.
    - At 63, `cursor_x` holds with no wrap, so later characters overwrite column 63.
  - **0x0D (CR):** `cursor_x=0`.
  - **0x08 (BS):** decrement `cursor_x`, saturating at 0.
  - **0x0A (LF):**
    - If `cursor_y<15`, increment `cursor_y`.
    - Otherwise scroll: `first_row` increments (wraps), then CLEAR blanks logical row 15 for columns 0–63. That is physical row = the old `first_row`, 64 writes.
  - **0x1B:** go to ESC.
  - **Any other byte:** ignored.
- **In ESC** (every byte returns to IDLE unless noted):
  - `A`: `cursor_y` decrements, saturating at 0.
  - `B`: `cursor_y` increments, saturating at 15, no scroll.
  - `C`: `cursor_x` increments, saturating at 63.
  - `D`: `cursor_x` decrements, saturating at 0.
  - `H`: cursor goes to (0,0).
  - `K`: CLEAR from the cursor to column 63 of the current row.
  - `J`: CLEAR from the cursor to the end of logical row 15.
  - `Y`: go to Y_ROW.
  - Any other byte: ignored.
- **In Y_ROW:** latch `data_in-0x20`, clamped to 15, then go to Y_COL.
- **In Y_COL:**
  - Set `cursor_x = data_in-0x20`, clamped to 63.
  - Set `cursor_y` to the latched row, then return to IDLE.
  - Argument bytes below 0x20 clamp to 0.
- **CLEAR behaviour:**
  - Walks logical addresses linearly: column wraps 63→0 with row+1.
  - Writes `BLANK` to each address.
  - Stops after the end column/row, then returns to IDLE.
  - Cursor is never moved by CLEAR.
- **`data_ready`** is 1 in IDLE, ESC, Y_ROW and Y_COL, and 0 in CLEAR.

## Timing
- All outputs are registered except `data_ready`, which decodes the state register.
- **Reset values:**
  - `cursor_x=0`, `cursor_y=0`, `first_row=0`
  - `buf_wen=0`, `buf_addr=0`, `buf_din=BLANK`
  - state IDLE, `data_ready=1`
- **Printable byte accepted at edge k:**
  - From edge k, `buf_wen=1` with the address computed from the pre-advance cursor.
  - The advanced `cursor_x` is visible from the same edge.
  - `buf_wen` drops at edge k+1 unless another printable byte is accepted at k+1, so back-to-back writes at one per cycle are supported.
- **Clear of N cells started by a byte accepted at edge k:**
  - `data_ready=0` from edge k.
  - `buf_wen=1` for exactly edges k+1 … k+N, with `buf_addr` advancing by one each cycle.
  - IDLE and `data_ready=1` from edge k+N.
  - N = 64 for scroll; 64−`cursor_x` for K; (15−`cursor_y`)·64 + 64−`cursor_x` for J, maximum 1024.
- **Scroll:** `first_row` updates at the accept edge. The recycled row is addressed with the new offset, as logical row 15.
- **Non-writing bytes:** `buf_wen` stays 0. The cursor updates at the accept edge.
- **`clr` mid-CLEAR or mid-sequence:** outputs return to reset values immediately. A partial clear is left as is and a pending ESC is discarded.
- **`data_valid` ignored** while `data_ready=0`. The upstream holds the byte.

## Test plan
- Reset, send 'A','B' on consecutive cycles → writes (addr 0, 0x41), (addr 1, 0x42) on consecutive cycles; `cursor_x=2`.
- 64×'X' then 'Y' → writes addresses 0–63, then 'Y' again at address 63; `cursor_x` holds at 63.
- ESC Y 0x25 0x2A → `cursor_y=5`, `cursor_x=10`, no writes; ESC Y 0x7F 0x7F → (15,63).
- ESC Y to (15,3), then LF → `first_row=1`; 64 writes of 0x20 to addresses 0–63; `data_ready` low for 64 cycles; next 'Z' writes address 3 (physical row 0).
- Cursor (2,60), ESC K → 4 writes of 0x20 to addresses 188–191; cursor unchanged. Cursor (15,62), ESC J → addresses 1022 and 1023.
- Assert `clr` during the 10th cycle of an ESC J clear → `buf_wen=0`, `data_ready=1`, cursor (0,0), `first_row=0` without waiting for a clock edge.
